// File: rtl/fiber_feeder_pkg.sv
// Shared types and defaults for the fiber feeder: coordinate width, FIFO depth
// and the feeder state encoding used by the merger lanes.
package fiber_feeder_pkg;

    localparam int COORD_BITS   = 8;
    localparam int FEEDER_DEPTH = 4;

    typedef enum logic [1:0] {
        FEED_IDLE   = 2'd0,
        FEED_STREAM = 2'd1,
        FEED_DRAIN  = 2'd2,
        FEED_DONE   = 2'd3
    } feed_state_t;

endpackage

// File: rtl/fiber_feeder_fifo.sv
// Circular FIFO of {last, coord} entries with natural pointer wrap and an
// occupancy count; the caller guarantees no push when full without a pop.
module fiber_feeder_fifo #(
    parameter int COORD_W  = 8,
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                push,
    input  logic                pop,
    input  logic                push_last,
    input  logic [COORD_W-1:0]  push_coord,
    output logic                head_last,
    output logic [COORD_W-1:0]  head_coord,
    output logic                full,
    output logic                empty
);

    logic [PTR_BITS-1:0] rd_ptr;
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS:0]   count;
    logic [COORD_W:0]    mem [DEPTH];

    // Storage carries no reset: stale entries are hidden by count == 0.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {push_last, push_coord};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign {head_last, head_coord} = mem[rd_ptr];
    assign full  = (count == (PTR_BITS+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fiber_feeder.sv
// Producer side of one merger lane: buffers a fiber's coordinates, presents the
// head (or an all-ones sentinel) and tracks fiber completion and underflow.
module fiber_feeder
    import fiber_feeder_pkg::*;
#(
    parameter int FEEDER_COORD_BITS = COORD_BITS,
    parameter int FEEDER_DEPTH      = fiber_feeder_pkg::FEEDER_DEPTH,
    parameter int FEEDER_PTR_BITS   = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [FEEDER_COORD_BITS-1:0] load_coord,
    input  logic                         load_last,
    input  logic                         load_valid,
    output logic                         load_ready,
    output logic [FEEDER_COORD_BITS-1:0] coord,
    output logic                         head_valid,
    input  logic                         fetch_next,
    output logic                         fiber_done,
    output logic                         underflow
);

    feed_state_t                  state;
    logic                         push;
    logic                         pop;
    logic                         full;
    logic                         empty;
    logic                         head_last;
    logic [FEEDER_COORD_BITS-1:0] head_coord;

    assign head_valid = !empty;
    assign pop        = fetch_next && head_valid;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign load_ready = (!full || pop) && (state != FEED_DRAIN);
    assign push       = load_valid && load_ready;
    assign coord      = head_valid ? head_coord : {FEEDER_COORD_BITS{1'b1}};

    fiber_feeder_fifo #(
        .COORD_W  (FEEDER_COORD_BITS),
        .DEPTH    (FEEDER_DEPTH),
        .PTR_BITS (FEEDER_PTR_BITS)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .push_last  (load_last),
        .push_coord (load_coord),
        .head_last  (head_last),
        .head_coord (head_coord),
        .full       (full),
        .empty      (empty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= FEED_IDLE;
            fiber_done <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (fetch_next && !head_valid) begin
                underflow <= 1'b1;
            end
            case (state)
                FEED_IDLE, FEED_STREAM, FEED_DONE: begin
                    if (push) begin
                        state      <= load_last ? FEED_DRAIN : FEED_STREAM;
                        fiber_done <= 1'b0;
                    end
                end
                FEED_DRAIN: begin
                    if (pop && head_last) begin
                        state      <= FEED_DONE;
                        fiber_done <= 1'b1;
                    end
                end
                default: state <= FEED_IDLE;
            endcase
        end
    end

endmodule
